// File: rtl/matmul_apb_master_if.sv
// Bus bundle for matmul_apb_master: job command/response handshake plus the
// APB requester signals, with a debug view of the sequencing FSM.
//
// Handshake semantics:
//   cmd : a job moves on a rising edge where cmd_valid & cmd_ready are both 1.
//         The cmd_* fields are sampled on that edge only. cmd_valid seen while
//         cmd_ready = 0 is ignored and never queued.
//   rsp : rsp_valid is a one-cycle pulse with no back-pressure. rsp_flags and
//         rsp_err stay stable after the pulse until the next job completes.
//   apb : psel=1/penable=0 marks SETUP. psel=1/penable=1 is ACCESS, which
//         completes on the first edge with pready = 1. pslverr is only
//         meaningful on that completing edge.
interface matmul_apb_master_if #(
  parameter int AWIDTH   = 10,
  parameter int STRIDE_W = 8
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [AWIDTH-1:0]   cmd_addr_a;
  logic [AWIDTH-1:0]   cmd_addr_b;
  logic [AWIDTH-1:0]   cmd_addr_c;
  logic [STRIDE_W-1:0] cmd_stride_a;
  logic [STRIDE_W-1:0] cmd_stride_b;
  logic [STRIDE_W-1:0] cmd_stride_c;
  logic                cmd_is_fp8;

  logic                rsp_valid;
  logic [4:0]          rsp_flags;
  logic                rsp_err;
  logic                busy;

  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [7:0]          paddr;
  logic [31:0]         pwdata;
  logic [31:0]         prdata;
  logic                pready;
  logic                pslverr;

  // Encoded FSM state, for checkers and waveform debug.
  logic [2:0]          dbg_state;

  modport master (
    input  cmd_valid, cmd_addr_a, cmd_addr_b, cmd_addr_c,
    input  cmd_stride_a, cmd_stride_b, cmd_stride_c, cmd_is_fp8,
    output cmd_ready, rsp_valid, rsp_flags, rsp_err, busy,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr,
    output dbg_state
  );

  modport slave (
    output cmd_valid, cmd_addr_a, cmd_addr_b, cmd_addr_c,
    output cmd_stride_a, cmd_stride_b, cmd_stride_c, cmd_is_fp8,
    input  cmd_ready, rsp_valid, rsp_flags, rsp_err, busy,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr,
    input  dbg_state
  );
endinterface

// File: rtl/matmul_apb_master.sv
// APB requester that programs a matrix-multiply engine for one job.
// It writes the A/B/C base addresses and strides, then sets CTRL.start. It
// polls STATUS until done, captures the flags, and clears CTRL.start. Finally
// it emits a one-cycle response. A pslverr on any transfer aborts the job
// and no further transfers are issued.
module matmul_apb_master #(
  parameter int AWIDTH   = 10,
  parameter int STRIDE_W = 8,
  parameter int POLL_GAP = 4
) (
  input  logic                clk,
  input  logic                reset,
  matmul_apb_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_ACCESS    = 3'd2,
    S_POLL_WAIT = 3'd3,
    S_RESP      = 3'd4
  } state_e;

  // Poll counter reloads with POLL_GAP-1 and counts down to 0, so
  // POLL_WAIT lasts exactly POLL_GAP cycles.
  localparam int             PCW         = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [PCW-1:0] POLL_RELOAD = PCW'(POLL_GAP - 1);

  // Register map (byte addresses).
  localparam logic [7:0] REG_CTRL     = 8'h00;
  localparam logic [7:0] REG_STATUS   = 8'h04;
  localparam logic [7:0] REG_ADDR_A   = 8'h08;
  localparam logic [7:0] REG_ADDR_B   = 8'h0C;
  localparam logic [7:0] REG_ADDR_C   = 8'h10;
  localparam logic [7:0] REG_STRIDE_A = 8'h14;
  localparam logic [7:0] REG_STRIDE_B = 8'h18;
  localparam logic [7:0] REG_STRIDE_C = 8'h1C;

  // Transfer sequence index. Steps 0-5 write the address and stride
  // registers, 6 sets start, 7 reads STATUS (repeated while not done), and
  // 8 clears start.
  localparam logic [3:0] STEP_STATUS   = 4'd7;
  localparam logic [3:0] STEP_CTRL_CLR = 4'd8;

  state_e              state_q;
  logic [3:0]          step_q;
  logic [PCW-1:0]      poll_cnt_q;

  logic [AWIDTH-1:0]   addr_a_q;
  logic [AWIDTH-1:0]   addr_b_q;
  logic [AWIDTH-1:0]   addr_c_q;
  logic [STRIDE_W-1:0] stride_a_q;
  logic [STRIDE_W-1:0] stride_b_q;
  logic [STRIDE_W-1:0] stride_c_q;
  logic                fp8_q;

  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [7:0]          paddr_q;
  logic [31:0]         pwdata_q;

  logic [4:0]          flags_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [4:0]          rsp_flags_q;

  logic [3:0]          nxt_step;
  logic [7:0]          nxt_paddr;
  logic                nxt_pwrite;
  logic [31:0]         nxt_pwdata;

  // Only STATUS bits [5:0] carry meaning.
  logic                unused_prdata;
  assign unused_prdata = ^bus.prdata[31:6];

  // Address/direction/data of the transfer that follows the current step.
  always_comb begin
    nxt_step   = step_q + 4'd1;
    nxt_paddr  = REG_CTRL;
    nxt_pwrite = 1'b1;
    nxt_pwdata = '0;
    case (nxt_step)
      4'd1: begin
        nxt_paddr  = REG_ADDR_B;
        nxt_pwdata = 32'(addr_b_q);
      end
      4'd2: begin
        nxt_paddr  = REG_ADDR_C;
        nxt_pwdata = 32'(addr_c_q);
      end
      4'd3: begin
        nxt_paddr  = REG_STRIDE_A;
        nxt_pwdata = 32'(stride_a_q);
      end
      4'd4: begin
        nxt_paddr  = REG_STRIDE_B;
        nxt_pwdata = 32'(stride_b_q);
      end
      4'd5: begin
        nxt_paddr  = REG_STRIDE_C;
        nxt_pwdata = 32'(stride_c_q);
      end
      4'd6: begin
        nxt_paddr  = REG_CTRL;
        nxt_pwdata = {30'd0, fp8_q, 1'b1};
      end
      4'd7: begin
        nxt_paddr  = REG_STATUS;
        nxt_pwrite = 1'b0;
      end
      4'd8: begin
        nxt_paddr  = REG_CTRL;
        nxt_pwdata = {30'd0, fp8_q, 1'b0};
      end
      default: begin
        nxt_pwrite = 1'b0;
      end
    endcase
  end

  // Job sequencer: state, APB outputs and response registers together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      poll_cnt_q  <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      addr_c_q    <= '0;
      stride_a_q  <= '0;
      stride_b_q  <= '0;
      stride_c_q  <= '0;
      fp8_q       <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      flags_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_flags_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            addr_a_q   <= bus.cmd_addr_a;
            addr_b_q   <= bus.cmd_addr_b;
            addr_c_q   <= bus.cmd_addr_c;
            stride_a_q <= bus.cmd_stride_a;
            stride_b_q <= bus.cmd_stride_b;
            stride_c_q <= bus.cmd_stride_c;
            fp8_q      <= bus.cmd_is_fp8;
            // The first transfer is loaded straight from the command so
            // that SETUP appears on the cycle after acceptance.
            step_q     <= '0;
            psel_q     <= 1'b1;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b1;
            paddr_q    <= REG_ADDR_A;
            pwdata_q   <= 32'(bus.cmd_addr_a);
            state_q    <= S_SETUP;
          end
        end

        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
        end

        S_ACCESS: begin
          // Address, direction and data are held until pready completes
          // the transfer.
          if (bus.pready) begin
            if (bus.pslverr) begin
              psel_q      <= 1'b0;
              penable_q   <= 1'b0;
              pwrite_q    <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_flags_q <= '0;
              state_q     <= S_RESP;
            end else if (step_q == STEP_STATUS && !bus.prdata[0]) begin
              psel_q     <= 1'b0;
              penable_q  <= 1'b0;
              poll_cnt_q <= POLL_RELOAD;
              state_q    <= S_POLL_WAIT;
            end else if (step_q == STEP_CTRL_CLR) begin
              psel_q      <= 1'b0;
              penable_q   <= 1'b0;
              pwrite_q    <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_flags_q <= flags_q;
              state_q     <= S_RESP;
            end else begin
              if (step_q == STEP_STATUS) begin
                flags_q <= bus.prdata[5:1];
              end
              step_q    <= nxt_step;
              penable_q <= 1'b0;
              paddr_q   <= nxt_paddr;
              pwrite_q  <= nxt_pwrite;
              pwdata_q  <= nxt_pwdata;
              state_q   <= S_SETUP;
            end
          end
        end

        S_POLL_WAIT: begin
          if (poll_cnt_q == '0) begin
            psel_q   <= 1'b1;
            paddr_q  <= REG_STATUS;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            state_q  <= S_SETUP;
          end else begin
            poll_cnt_q <= poll_cnt_q - PCW'(1);
          end
        end

        S_RESP: begin
          state_q <= S_IDLE;
        end

        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign bus.dbg_state = state_q;

endmodule

// File: doc/matmul_apb_master.md
MATMUL_APB_MASTER -- requirements
Module: matmul_apb_master

Interface
REQ-001 Parameters (name, default, meaning): AWIDTH, 10, matrix base-address width; STRIDE_W, 8, address-stride width; POLL_GAP, 4, idle cycles between STATUS polls (>=1).
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge.
- reset, in, 1, asynchronous, active-high.
- cmd_valid, in, 1, job request.
- cmd_ready, out, 1, block can accept a job.
- cmd_addr_a / cmd_addr_b / cmd_addr_c, in, AWIDTH each, matrix base addresses.
- cmd_stride_a / cmd_stride_b / cmd_stride_c, in, STRIDE_W each, address strides.
- cmd_is_fp8, in, 1, selects FP8 mode.
- rsp_valid, out, 1, one-cycle job-complete pulse.
- rsp_flags, out, 5, STATUS flags captured at completion.
- rsp_err, out, 1, job aborted on PSLVERR.
- busy, out, 1, job in progress.
- psel, penable, pwrite, out, 1 each, APB control.
- paddr, out, 8, APB byte address.
- pwdata, out, 32, APB write data.
- prdata, in, 32, APB read data.
- pready, pslverr, in, 1 each, APB completer response.

Function
REQ-003 Register map (word-aligned): 0x00 CTRL (bit0 start, bit1 is_fp8); 0x04 STATUS (bit0 done, bits[5:1] flags); 0x08/0x0C/0x10 ADDR_A/B/C (zero-extended); 0x14/0x18/0x1C STRIDE_A/B/C (zero-extended).
REQ-004 cmd_ready = 1 only in IDLE; the handshake is cmd_valid & cmd_ready; all cmd_* fields are latched on the accepting edge.
REQ-005 States: IDLE, SETUP, ACCESS, POLL_WAIT, RESP.
REQ-006 Job sequence, in order: write ADDR_A, ADDR_B, ADDR_C, STRIDE_A, STRIDE_B, STRIDE_C; write CTRL = {is_fp8, 1}; read STATUS until done = 1; write CTRL = {is_fp8, 0}; RESP.
REQ-007 Each APB transfer takes SETUP for 1 cycle (psel = 1, penable = 0, paddr/pwrite/pwdata valid), then ACCESS (psel = 1, penable = 1) until pready = 1.
REQ-008 paddr, pwrite and pwdata SHALL remain stable from SETUP through the completing ACCESS cycle.
REQ-009 The next transfer's SETUP follows the completing ACCESS cycle directly, with no idle cycle in between, except where REQ-010 applies.
REQ-010 STATUS read completing with done = 0: enter POLL_WAIT with psel = 0 for exactly POLL_GAP cycles, then SETUP a new STATUS read.
REQ-011 STATUS read completing with done = 1: capture prdata[5:1] into the flags register.
REQ-012 pwdata = 0 during reads; psel = penable = 0 in IDLE, POLL_WAIT and RESP.
REQ-013 Minimum latency with pready tied high and done seen on the first poll: first SETUP on the cycle after acceptance; rsp_valid 19 cycles after the accepting edge (9 transfers x 2 cycles, plus RESP).
REQ-014 RESP lasts exactly 1 cycle: rsp_valid = 1; rsp_flags and rsp_err valid. Next state is IDLE.
REQ-015 rsp_flags and rsp_err hold their values until the next job's RESP.
REQ-016 pslverr = 1 on a completing ACCESS cycle of any transfer aborts the job:
- go to RESP with rsp_err = 1 and rsp_flags = 0;
- no further transfers are issued, including the CTRL clear.
REQ-017 busy = 1 in every state except IDLE.
REQ-018 cmd_valid asserted while busy is ignored; there is no queueing.
REQ-019 A new job may be accepted on the cycle after RESP.
REQ-020 pready held low indefinitely: the block stays in ACCESS. There is no timeout.

Reset
REQ-021 reset = 1 SHALL immediately (asynchronously) force the following, regardless of state, including mid-transfer:
- state = IDLE;
- psel, penable, pwrite, rsp_valid, rsp_err, busy = 0;
- paddr, pwdata, rsp_flags, all latched command fields = 0;
- poll counter = 0.
REQ-022 cmd_ready = 1 on the first clock edge after reset deasserts.

Verification
REQ-023 Nominal job:
- stimulus: addr_a = 0x010, addr_b = 0x020, addr_c = 0x030, strides = 1/2/3, is_fp8 = 0, pready = 1, done returned on the first poll with flags = 0x00;
- response: APB writes in REQ-006 order with pwdata 0x10, 0x20, 0x30, 1, 2, 3, 0x1, then the STATUS read, then 0x0; rsp_valid at cycle 19 with rsp_flags = 0, rsp_err = 0.
REQ-024 Polling:
- stimulus: done returned on the 3rd STATUS read;
- response: exactly 3 STATUS reads, each pair separated by exactly POLL_GAP (4) cycles with psel = 0.
REQ-025 Wait states and FP8:
- stimulus: pready low for 3 cycles on every ACCESS; is_fp8 = 1; STATUS = 0x2B (done = 1, flags = 0x15);
- response: paddr and pwdata stable through every wait; CTRL writes are 0x3 then 0x2; rsp_flags = 0x15.
REQ-026 Error abort:
- stimulus: pslverr = 1 on the STRIDE_A write;
- response: no further psel assertion; rsp_valid with rsp_err = 1 and rsp_flags = 0; cmd_ready = 1 on the next cycle.
REQ-027 Reset mid-operation:
- stimulus: reset asserted during the ACCESS phase of the ADDR_C write;
- response: psel, penable and busy drop to 0 without waiting for a clock edge; after release a new job runs from ADDR_A.
REQ-028 Busy rejection:
- stimulus: cmd_valid held high for the whole of a running job, presenting different field values;
- response: the running job's register writes are unaffected; the next job is accepted only on the cycle after RESP.
